// File: rtl/async_oneway_tx_scheduler.sv
// Transmit scheduler for the 6-bit one-way link: round-robin grant between two sources,
// then LSB-chunk-first serialization with debounce-safe packet_pulse strobes and a final commit strobe.
module async_oneway_tx_scheduler #(
  parameter int MESSAGE_SIZE = 100,
  parameter int SETUP_CYC    = 8,
  parameter int HIGH_CYC     = 16,
  parameter int LOW_CYC      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic [MESSAGE_SIZE-1:0] msg0,
  output logic                    ack0,
  input  logic                    req1,
  input  logic [MESSAGE_SIZE-1:0] msg1,
  output logic                    ack1,
  output logic [5:0]              dout,
  output logic                    packet_pulse,
  output logic                    transmit_ctrl,
  output logic                    busy,
  output logic                    done
);

  localparam int NCHUNK  = (MESSAGE_SIZE + 5) / 6;
  localparam int PADW    = 6 * NCHUNK;
  localparam int CNT_MAX = (SETUP_CYC > HIGH_CYC) ?
                           ((SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC) :
                           ((HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_HIGH       = 3'd2,
    ST_LOW        = 3'd3,
    ST_COMMIT     = 3'd4,
    ST_COMMIT_LOW = 3'd5
  } state_e;

  state_e          state_q;
  logic            last_grant_q;
  logic [PADW-1:0] shreg_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   chunk_idx_q;
  logic            ack0_q;
  logic            ack1_q;
  logic [5:0]      dout_q;
  logic            packet_pulse_q;
  logic            transmit_ctrl_q;
  logic            busy_q;
  logic            done_q;

  logic            grant_vld_d;
  logic            grant_sel_d;
  logic [PADW-1:0] shreg_load_d;
  logic [PADW-1:0] shreg_shift_d;

  // Arbitration: a lone requester wins outright, a tie goes to the source not granted last.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_sel_d = 1'b0;
    if (req0 && req1) begin
      grant_vld_d = 1'b1;
      grant_sel_d = ~last_grant_q;
    end else if (req0) begin
      grant_vld_d = 1'b1;
      grant_sel_d = 1'b0;
    end else if (req1) begin
      grant_vld_d = 1'b1;
      grant_sel_d = 1'b1;
    end else begin
      grant_vld_d = 1'b0;
      grant_sel_d = 1'b0;
    end
  end

  // Zero-padded load image of the winning message and the next-chunk shift image.
  always_comb begin
    shreg_load_d  = grant_sel_d ? PADW'(msg1) : PADW'(msg0);
    shreg_shift_d = shreg_q >> 6;
  end

  // Sequencer: every state reloads the down-counter on entry and leaves when it reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= 1'b1;
      shreg_q         <= {PADW{1'b0}};
      cnt_q           <= {CW{1'b0}};
      chunk_idx_q     <= {IW{1'b0}};
      ack0_q          <= 1'b0;
      ack1_q          <= 1'b0;
      dout_q          <= 6'h00;
      packet_pulse_q  <= 1'b0;
      transmit_ctrl_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          packet_pulse_q  <= 1'b0;
          transmit_ctrl_q <= 1'b0;
          if (grant_vld_d) begin
            state_q      <= ST_SETUP;
            last_grant_q <= grant_sel_d;
            shreg_q      <= shreg_load_d;
            dout_q       <= shreg_load_d[5:0];
            cnt_q        <= CW'(SETUP_CYC - 1);
            chunk_idx_q  <= {IW{1'b0}};
            ack0_q       <= ~grant_sel_d;
            ack1_q       <= grant_sel_d;
            busy_q       <= 1'b1;
          end else begin
            dout_q <= 6'h00;
            busy_q <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (cnt_q == CW'(0)) begin
            state_q        <= ST_HIGH;
            cnt_q          <= CW'(HIGH_CYC - 1);
            packet_pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_HIGH: begin
          if (cnt_q == CW'(0)) begin
            state_q        <= ST_LOW;
            cnt_q          <= CW'(LOW_CYC - 1);
            packet_pulse_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_LOW: begin
          if (cnt_q == CW'(0)) begin
            if (chunk_idx_q == IW'(NCHUNK - 1)) begin
              state_q         <= ST_COMMIT;
              cnt_q           <= CW'(HIGH_CYC - 1);
              transmit_ctrl_q <= 1'b1;
            end else begin
              // dout only moves here, while both strobes are low
              state_q     <= ST_SETUP;
              cnt_q       <= CW'(SETUP_CYC - 1);
              shreg_q     <= shreg_shift_d;
              dout_q      <= shreg_shift_d[5:0];
              chunk_idx_q <= chunk_idx_q + IW'(1);
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_COMMIT: begin
          if (cnt_q == CW'(0)) begin
            state_q         <= ST_COMMIT_LOW;
            cnt_q           <= CW'(LOW_CYC - 1);
            transmit_ctrl_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_COMMIT_LOW: begin
          if (cnt_q == CW'(0)) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            dout_q  <= 6'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q         <= ST_IDLE;
          cnt_q           <= {CW{1'b0}};
          dout_q          <= 6'h00;
          packet_pulse_q  <= 1'b0;
          transmit_ctrl_q <= 1'b0;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign dout          = dout_q;
  assign packet_pulse  = packet_pulse_q;
  assign transmit_ctrl = transmit_ctrl_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_async_oneway_tx_scheduler.sv
// Bench for async_oneway_tx_scheduler: vector table plus hand sequences, with a scoreboard-driven
// stream monitor and a debouncing receiver model that reassembles each committed message.
module tb_async_oneway_tx_scheduler;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [99:0] msg0, msg1;
  logic        ack0, ack1;
  logic [5:0]  dout;
  logic        pp, tc, busy, done;

  async_oneway_tx_scheduler #(
    .MESSAGE_SIZE(100), .SETUP_CYC(8), .HIGH_CYC(16), .LOW_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .msg0(msg0), .ack0(ack0),
    .req1(req1), .msg1(msg1), .ack1(ack1),
    .dout(dout), .packet_pulse(pp), .transmit_ctrl(tc),
    .busy(busy), .done(done)
  );

  typedef struct {
    int          id;
    logic [99:0] msg;
  } sb_item_t;

  typedef struct {
    logic        r0;
    logic        r1;
    logic [99:0] m0;
    logic [99:0] m1;
    int          first_id;
    int          second_id;
    logic [5:0]  c0;
    logic [5:0]  c16;
  } vec_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Receiver model and stream monitor state
  logic [101:0] rx_buf = '0;
  logic [101:0] rx_pub = '0;
  logic         pp_db = 1'b0, tc_db = 1'b0;
  int           pp_dbc = 0, tc_dbc = 0;
  int           tc_rises = 0;
  logic         pp_prev = 1'b0, tc_prev = 1'b0;
  logic [5:0]   dout_prev = 6'h00;
  logic         active = 1'b0;
  int           rel = 0;
  int           chunk = 0;
  logic [101:0] pmsg = '0;
  logic [101:0] tmp;
  sb_item_t     it;

  initial forever begin
    @(negedge clk);
    // debounced receiver: shift on a settled rising packet_pulse, publish on a settled rising transmit_ctrl
    if (pp !== pp_db) begin
      pp_dbc++;
      if (pp_dbc == 4) begin
        pp_db = pp; pp_dbc = 0;
        if (pp) rx_buf = {dout, rx_buf[101:6]};
      end
    end else pp_dbc = 0;
    if (tc !== tc_db) begin
      tc_dbc++;
      if (tc_dbc == 4) begin
        tc_db = tc; tc_dbc = 0;
        if (tc) rx_pub = rx_buf;
      end
    end else tc_dbc = 0;
    if (tc && !tc_prev) tc_rises++;

    if (rst) begin
      active = 1'b0;
    end else if (ack0 || ack1) begin
      chk("ack_onehot", ack0 && ack1, 0);
      chk("ack_while_busy", active, 0);
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        it = sb.pop_front();
        chk("grant_id", ack1 ? 1 : 0, it.id);
        pmsg = {2'b00, it.msg};
      end
      active = 1'b1; rel = 1; chunk = 0;
      chk("first_dout", dout, pmsg[5:0]);
      chk("ack_busy", busy, 1);
    end else if (active) begin
      rel++;
      if (rel <= 712) chk("busy_hi", busy, 1);
      if (pp && !pp_prev) begin
        chk("pp_rise_cyc", rel, 9 + 40 * chunk);
        tmp = pmsg >> (6 * chunk);
        chk("chunk_data", dout, tmp[5:0]);
        chunk++;
      end
      if (!pp && pp_prev) chk("pp_fall_cyc", rel, 25 + 40 * (chunk - 1));
      if (dout != dout_prev && !done)
        chk("dout_chg_cyc", (rel > 1 && rel <= 641 && (rel - 1) % 40 == 0), 1);
      if (tc && !tc_prev) begin
        chk("tc_rise_cyc", rel, 681);
        chk("tc_after_chunks", chunk, 17);
      end
      if (!tc && tc_prev) chk("tc_fall_cyc", rel, 697);
      if (done) begin
        chk("done_cyc", rel, 713);
        chk("done_busy", busy, 0);
        chk("rx_commit", rx_pub, pmsg);
        active = 1'b0;
      end else if (rel >= 900) begin
        chk("done_timeout", rel, 713);
        active = 1'b0;
      end
    end else begin
      chk("idle_quiet", {done, pp, tc}, 0);
    end
    pp_prev = pp; tc_prev = tc; dout_prev = dout;
  end

  vec_t        tbl[5];
  vec_t        v;
  int          ids[2];
  int          nack, ndone, nexp, nrise, ack2_cyc, done1_cyc, tcr0;
  logic [5:0]  c0_cap, c16_cap;
  logic        pp_p, got;
  logic [101:0] pub0;
  logic [99:0] xmsg, ymsg, zmsg, wmsg;

  task automatic push(input int id, input logic [99:0] m);
    sb_item_t s;
    s.id = id; s.msg = m;
    sb.push_back(s);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 100'h1, 100'h0, 0, -1, 6'h01, 6'h00};
    tbl[1] = '{1'b1, 1'b0, {100{1'b1}}, 100'h0, 0, -1, 6'h3F, 6'h0F};
    tbl[2] = '{1'b0, 1'b1, 100'h0, 100'h8_0000_0000_0000_0000_0000_002A, 1, -1, 6'h2A, 6'h08};
    tbl[3] = '{1'b1, 1'b1, 100'h3_0000_0000_0000_0000_0000_0015,
               100'h1_2345_6789_ABCD_EF01_2345_6789, 0, 1, 6'h15, 6'h03};
    tbl[4] = '{1'b1, 1'b1, 100'hA_0000_0000_0000_0000_0000_002C,
               100'h5_5555_AAAA_5555_AAAA_5555_AAAA, 0, 1, 6'h2C, 6'h0A};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; msg0 = '0; msg1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_pp", pp, 0);
    chk("rst_tc", tc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", {ack0, ack1}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      v = tbl[k];
      nexp = (v.second_id >= 0) ? 2 : 1;
      if (v.first_id == 0) push(0, v.m0); else push(1, v.m1);
      if (nexp == 2) begin
        if (v.second_id == 0) push(0, v.m0); else push(1, v.m1);
      end
      msg0 = v.m0; msg1 = v.m1; req0 = v.r0; req1 = v.r1;
      nack = 0; ndone = 0; nrise = 0; pp_p = 1'b0;
      ids[0] = -1; ids[1] = -1; ack2_cyc = 0; done1_cyc = 0;
      c0_cap = 6'h00; c16_cap = 6'h00;
      for (int n = 0; n < 2000 && ndone < nexp; n++) begin
        @(negedge clk);
        if (ack0 || ack1) begin
          if (nack < 2) ids[nack] = ack1 ? 1 : 0;
          if (nack == 1) ack2_cyc = cyc;
          nack++;
          if (ack0) req0 = 1'b0;
          if (ack1) req1 = 1'b0;
        end
        if (pp && !pp_p && ndone == 0) begin
          if (nrise == 0) c0_cap = dout;
          c16_cap = dout;
          nrise++;
        end
        pp_p = pp;
        if (done) begin
          if (ndone == 0) done1_cyc = cyc;
          ndone++;
        end
      end
      chk($sformatf("v%0d_dones", k), ndone, nexp);
      chk($sformatf("v%0d_first_id", k), ids[0], v.first_id);
      chk($sformatf("v%0d_rises", k), nrise, 17);
      chk($sformatf("v%0d_chunk0", k), c0_cap, v.c0);
      chk($sformatf("v%0d_chunk16", k), c16_cap, v.c16);
      if (nexp == 2) begin
        chk($sformatf("v%0d_second_id", k), ids[1], v.second_id);
        chk($sformatf("v%0d_ack2_after_done", k), ack2_cyc, done1_cyc + 1);
      end
    end

    // req1/msg1 churn while req0's message is in flight
    xmsg = 100'hF_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    ymsg = 100'h6_DEAD_BEEF_CAFE_F00D_1357_9BDF;
    push(0, xmsg);
    msg0 = xmsg; req0 = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack0) got = 1'b1;
    end
    chk("A_ack0", got, 1);
    req0 = 1'b0;
    for (int n = 0; n < 690; n++) begin
      req1 = 1'($urandom_range(0, 1));
      msg1 = 100'({$urandom, $urandom, $urandom, $urandom});
      @(negedge clk);
      chk("A_no_ack1_busy", ack1, 0);
    end
    msg1 = ymsg; req1 = 1'b1;
    push(1, ymsg);
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else chk("A_no_ack1_late", ack1, 0);
    end
    chk("A_done", got, 1);
    @(negedge clk);
    chk("A_ack1_after_done", ack1, 1);
    req1 = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("A_done2", got, 1);

    // reset in the HIGH phase of chunk 5, then a clean message
    zmsg = 100'h9_8765_4321_0FED_CBA9_8765_4321;
    wmsg = 100'h2_4681_3579_ACE0_BDF1_2468_ACE0;
    push(0, zmsg);
    msg0 = zmsg; req0 = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack0) got = 1'b1;
    end
    chk("B_ack0", got, 1);
    req0 = 1'b0;
    repeat (214) @(negedge clk);
    chk("B_pp_high", pp, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("B_rst_dout", dout, 0);
    chk("B_rst_pp", pp, 0);
    chk("B_rst_tc", tc, 0);
    chk("B_rst_busy", busy, 0);
    chk("B_rst_done_ack", {done, ack0, ack1}, 0);
    @(negedge clk);
    rst = 1'b0;
    tcr0 = tc_rises; pub0 = rx_pub;
    repeat (800) @(negedge clk);
    chk("B_no_commit", tc_rises, tcr0);
    chk("B_pub_kept", rx_pub, pub0);
    chk("B_idle", busy, 0);
    push(0, wmsg);
    msg0 = wmsg; req0 = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack0) got = 1'b1;
    end
    chk("B_ack0_again", got, 1);
    req0 = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("B_done", got, 1);
    @(negedge clk);
    chk("B_rx_final", rx_pub, {2'b00, wmsg});
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
